// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage request sequencer.
// Contents:
//   - state_e       : sequencer FSM states (IDLE, WAIT, DONE, ABORT, RELEASE)
//   - CTRL_MULTI    : OP_CTRL/CTRL bit selecting a multi-value access
//   - CTRL_VERT     : OP_CTRL/CTRL bit selecting a vertical access
//   - ADDR_W/DATA_W/TAG_W/CTRL_W/TO_W : datapath widths
//   - op_advances() : true in the states where the upstream pipeline moves on
package mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 48;
    localparam int TAG_W  = 5;
    localparam int CTRL_W = 2;
    localparam int TO_W   = 16;

    // Bit positions inside the controller Ctrl field.
    localparam int CTRL_MULTI = 0;
    localparam int CTRL_VERT  = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        DONE    = 3'd2,
        ABORT   = 3'd3,
        RELEASE = 3'd4
    } state_e;

    // The op held in EX/MEM is consumed exactly when the sequencer finishes
    // with it, either with a result or with a timeout.
    function automatic logic op_advances(input state_e s);
        return (s == DONE) || (s == ABORT);
    endfunction

endpackage

// File: rtl/mem_tick_gen.sv
// Free-running CLK_MEM tick generator.
// Parameters:
//   MEM_DIV : CLK cycles per tick (1..255); 1 keeps CLK_MEM high every cycle.
// Ports:
//   CLK     : system clock
//   RESET   : asynchronous, active-high reset (counter 0, CLK_MEM 0)
//   CLK_MEM : one-CLK-wide tick, high while the counter sits at MEM_DIV-1
module mem_tick_gen #(
    parameter int MEM_DIV = 4
) (
    input  logic CLK,
    input  logic RESET,
    output logic CLK_MEM
);

    localparam logic [7:0] CNT_LAST = 8'(MEM_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       tick_q;
    logic       tick_d;

    // Next counter value and its tick; the tick is registered so CLK_MEM is
    // glitch-free and held low during reset even when MEM_DIV is 1.
    always_comb begin
        cnt_d = 8'd0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        tick_d = (cnt_d == CNT_LAST);
    end

    // Counter and tick registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q  <= 8'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign CLK_MEM = tick_q;

endmodule

// File: rtl/mem_request_sequencer.sv
// Memory-stage sequencer: issues one load op at a time to the matrix memory
// controller, stalls the pipeline until HANDSHAKE, captures READ for
// writeback and waits for the controller to drop HANDSHAKE before the next op.
// Build option: MEM_REQ_TIMEOUT_EN adds the WAIT timeout, ABORT state and the
// ERROR strobe; without it WAIT waits indefinitely and ERROR is tied to 0.
// Ports:
//   CLK, RESET (async, active-high)
//   OP_VALID/OP_CTRL/OP_ADDR/OP_RD : load op from EX/MEM
//   HANDSHAKE/READ                 : controller data-ready and result
//   ENABLE/CTRL/ADDRESS/CLK_MEM    : controller request and memory tick
//   STALL                          : freeze upstream pipeline (combinational)
//   WB_VALID/WB_DATA/WB_RD         : writeback strobe, data and tag
//   ERROR                          : one-cycle timeout strobe
module mem_request_sequencer
    import mem_pkg::*;
#(
    parameter int MEM_DIV     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              OP_VALID,
    input  logic [CTRL_W-1:0] OP_CTRL,
    input  logic [ADDR_W-1:0] OP_ADDR,
    input  logic [TAG_W-1:0]  OP_RD,
    input  logic              HANDSHAKE,
    input  logic [DATA_W-1:0] READ,
    output logic              ENABLE,
    output logic [CTRL_W-1:0] CTRL,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic              CLK_MEM,
    output logic              STALL,
    output logic              WB_VALID,
    output logic [DATA_W-1:0] WB_DATA,
    output logic [TAG_W-1:0]  WB_RD,
    output logic              ERROR
);

    state_e            state_q, state_d;
    logic              enable_q, enable_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TAG_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_valid_q, wb_valid_d;
`ifdef MEM_REQ_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              error_q, error_d;
`endif

    mem_tick_gen #(
        .MEM_DIV (MEM_DIV)
    ) u_tick (
        .CLK     (CLK),
        .RESET   (RESET),
        .CLK_MEM (CLK_MEM)
    );

    // Next-state and registered-output logic of the request FSM.
    always_comb begin
        state_d    = state_q;
        enable_d   = enable_q;
        ctrl_d     = ctrl_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        error_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // A HANDSHAKE still high here is stale and deliberately ignored.
                if (OP_VALID) begin
                    ctrl_d   = OP_CTRL;
                    addr_d   = OP_ADDR;
                    rd_d     = OP_RD;
                    enable_d = 1'b1;
`ifdef MEM_REQ_TIMEOUT_EN
                    to_cnt_d = 16'd0;
`endif
                    state_d  = WAIT;
                end else begin
                    state_d  = IDLE;
                end
            end
            WAIT: begin
                if (HANDSHAKE) begin
                    wb_data_d  = READ;
                    wb_valid_d = 1'b1;
                    state_d    = DONE;
`ifdef MEM_REQ_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    error_d    = 1'b1;
                    state_d    = ABORT;
                end else begin
                    to_cnt_d   = to_cnt_q + 16'd1;
                    state_d    = WAIT;
                end
`else
                end else begin
                    state_d    = WAIT;
                end
`endif
            end
            DONE: begin
                enable_d = 1'b0;
                state_d  = RELEASE;
            end
`ifdef MEM_REQ_TIMEOUT_EN
            ABORT: begin
                enable_d = 1'b0;
                state_d  = RELEASE;
            end
`endif
            RELEASE: begin
                // Leave only once the controller has dropped HANDSHAKE, i.e.
                // it has been back through its own idle state.
                enable_d = 1'b0;
                if (!HANDSHAKE) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                enable_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            enable_q   <= 1'b0;
            ctrl_q     <= {CTRL_W{1'b0}};
            addr_q     <= {ADDR_W{1'b0}};
            rd_q       <= {TAG_W{1'b0}};
            wb_data_q  <= {DATA_W{1'b0}};
            wb_valid_q <= 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
            to_cnt_q   <= 16'd0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            ctrl_q     <= ctrl_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
`ifdef MEM_REQ_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            error_q    <= error_d;
`endif
        end
    end

    // RESET gating keeps STALL low while reset is held even if OP_VALID is up.
    assign STALL    = OP_VALID && !RESET && !op_advances(state_q);
    assign ENABLE   = enable_q;
    assign CTRL     = ctrl_q;
    assign ADDRESS  = addr_q;
    assign WB_VALID = wb_valid_q;
    assign WB_DATA  = wb_data_q;
    assign WB_RD    = rd_q;
`ifdef MEM_REQ_TIMEOUT_EN
    assign ERROR    = error_q;
`else
    assign ERROR    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Directed self-checking bench for mem_request_sequencer (MEM_DIV = 4,
// TIMEOUT_CYC = 8) plus a second instance with MEM_DIV = 1 for the tick test.
module tb_mem_request_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        OP_VALID;
    logic [1:0]  OP_CTRL;
    logic [31:0] OP_ADDR;
    logic [4:0]  OP_RD;
    logic        HANDSHAKE;
    logic [47:0] READ;
    logic        ENABLE;
    logic [1:0]  CTRL;
    logic [31:0] ADDRESS;
    logic        CLK_MEM;
    logic        STALL;
    logic        WB_VALID;
    logic [47:0] WB_DATA;
    logic [4:0]  WB_RD;
    logic        ERROR;

    logic        u1_enable, u1_clk_mem, u1_stall, u1_wb_valid, u1_error;
    logic [1:0]  u1_ctrl;
    logic [31:0] u1_address;
    logic [47:0] u1_wb_data;
    logic [4:0]  u1_wb_rd;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    mem_request_sequencer #(.MEM_DIV(4), .TIMEOUT_CYC(8)) dut (
        .CLK(CLK), .RESET(RESET), .OP_VALID(OP_VALID), .OP_CTRL(OP_CTRL),
        .OP_ADDR(OP_ADDR), .OP_RD(OP_RD), .HANDSHAKE(HANDSHAKE), .READ(READ),
        .ENABLE(ENABLE), .CTRL(CTRL), .ADDRESS(ADDRESS), .CLK_MEM(CLK_MEM),
        .STALL(STALL), .WB_VALID(WB_VALID), .WB_DATA(WB_DATA), .WB_RD(WB_RD),
        .ERROR(ERROR)
    );

    mem_request_sequencer #(.MEM_DIV(1), .TIMEOUT_CYC(8)) dut_div1 (
        .CLK(CLK), .RESET(RESET), .OP_VALID(1'b0), .OP_CTRL(2'b00),
        .OP_ADDR(32'h0), .OP_RD(5'd0), .HANDSHAKE(1'b0), .READ(48'h0),
        .ENABLE(u1_enable), .CTRL(u1_ctrl), .ADDRESS(u1_address), .CLK_MEM(u1_clk_mem),
        .STALL(u1_stall), .WB_VALID(u1_wb_valid), .WB_DATA(u1_wb_data), .WB_RD(u1_wb_rd),
        .ERROR(u1_error)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; OP_VALID = 1'b1; OP_CTRL = 2'b11; OP_ADDR = 32'hFFFF_FFFF;
        OP_RD = 5'd31; HANDSHAKE = 1'b0; READ = 48'h0;
        tick(); tick(); tick();
        checks++; if (ENABLE !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", ENABLE); end
        checks++; if (CTRL !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b want 00", CTRL); end
        checks++; if (ADDRESS !== 32'h0) begin errors++; $display("FAIL reset_address: got %h want 0", ADDRESS); end
        checks++; if (CLK_MEM !== 1'b0) begin errors++; $display("FAIL reset_clk_mem: got %b want 0", CLK_MEM); end
        checks++; if (u1_clk_mem !== 1'b0) begin errors++; $display("FAIL reset_clk_mem_div1: got %b want 0", u1_clk_mem); end
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", STALL); end
        checks++; if (WB_VALID !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", WB_VALID); end
        checks++; if (WB_DATA !== 48'h0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", WB_DATA); end
        checks++; if (WB_RD !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %0d want 0", WB_RD); end
        checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", ERROR); end
        OP_VALID = 1'b0;
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        int n;
        int guard;
        OP_VALID = 1'b1; OP_CTRL = 2'b00; OP_ADDR = 32'h0002_0005; OP_RD = 5'd7;
        #1;
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL single_stall_idle: got %b want 1", STALL); end
        tick();
        checks++; if (ENABLE !== 1'b1) begin errors++; $display("FAIL single_enable: got %b want 1", ENABLE); end
        checks++; if (ADDRESS !== 32'h0002_0005) begin errors++; $display("FAIL single_address: got %h want 00020005", ADDRESS); end
        checks++; if (CTRL !== 2'b00) begin errors++; $display("FAIL single_ctrl: got %b want 00", CTRL); end
        n = 0; guard = 0;
        while (n < 3 && guard < 64) begin
            tick();
            guard++;
            if (CLK_MEM) n++;
            checks++; if (ENABLE !== 1'b1 || WB_VALID !== 1'b0 || STALL !== 1'b1) begin
                errors++; $display("FAIL single_wait: enable=%b wb_valid=%b stall=%b want 1 0 1", ENABLE, WB_VALID, STALL);
            end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL single_tick_wait: got %0d ticks want 3", n); end
        HANDSHAKE = 1'b1; READ = 48'hFFFF_FFFF_8001;
        tick();
        checks++; if (WB_VALID !== 1'b1) begin errors++; $display("FAIL single_wb_valid: got %b want 1", WB_VALID); end
        checks++; if (WB_DATA !== 48'hFFFF_FFFF_8001) begin errors++; $display("FAIL single_wb_data: got %h want ffffffff8001", WB_DATA); end
        checks++; if (WB_RD !== 5'd7) begin errors++; $display("FAIL single_wb_rd: got %0d want 7", WB_RD); end
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL single_stall_done: got %b want 0", STALL); end
        OP_VALID = 1'b0; READ = 48'h0;
        tick();
        checks++; if (WB_VALID !== 1'b0) begin errors++; $display("FAIL single_wb_valid_pulse: got %b want 0", WB_VALID); end
        checks++; if (ENABLE !== 1'b0) begin errors++; $display("FAIL single_enable_release: got %b want 0", ENABLE); end
        checks++; if (WB_DATA !== 48'hFFFF_FFFF_8001) begin errors++; $display("FAIL single_wb_data_hold: got %h want ffffffff8001", WB_DATA); end
        HANDSHAKE = 1'b0;
        tick();
        checks++; if (ENABLE !== 1'b0 || STALL !== 1'b0) begin errors++; $display("FAIL single_idle: enable=%b stall=%b want 0 0", ENABLE, STALL); end
    endtask

    task automatic test_horizontal_triple();
        OP_VALID = 1'b1; OP_CTRL = 2'b01; OP_ADDR = 32'h0001_0003; OP_RD = 5'd4;
        tick();
        checks++; if (CTRL !== 2'b01 || ENABLE !== 1'b1) begin errors++; $display("FAIL triple_accept: ctrl=%b enable=%b want 01 1", CTRL, ENABLE); end
        OP_CTRL = 2'b10; OP_ADDR = 32'hDEAD_BEEF;
        tick();
        checks++; if (ADDRESS !== 32'h0001_0003 || CTRL !== 2'b01) begin
            errors++; $display("FAIL triple_busy_ignore: address=%h ctrl=%b want 00010003 01", ADDRESS, CTRL);
        end
        HANDSHAKE = 1'b1; READ = 48'h0003_0002_0001;
        tick();
        checks++; if (WB_VALID !== 1'b1 || WB_DATA !== 48'h0003_0002_0001 || WB_RD !== 5'd4) begin
            errors++; $display("FAIL triple_done: wb_valid=%b data=%h rd=%0d want 1 000300020001 4", WB_VALID, WB_DATA, WB_RD);
        end
        // next op waits behind RELEASE while HANDSHAKE stays high
        OP_CTRL = 2'b00; OP_ADDR = 32'h0000_0001; OP_RD = 5'd1;
        tick();
        checks++; if (ENABLE !== 1'b0 || STALL !== 1'b1) begin errors++; $display("FAIL triple_release: enable=%b stall=%b want 0 1", ENABLE, STALL); end
        tick();
        checks++; if (ENABLE !== 1'b0 || STALL !== 1'b1 || ADDRESS !== 32'h0001_0003) begin
            errors++; $display("FAIL triple_hold_release: enable=%b stall=%b address=%h want 0 1 00010003", ENABLE, STALL, ADDRESS);
        end
        HANDSHAKE = 1'b0;
        tick();
        checks++; if (ENABLE !== 1'b0 || STALL !== 1'b1) begin errors++; $display("FAIL triple_idle: enable=%b stall=%b want 0 1", ENABLE, STALL); end
        tick();
        checks++; if (ENABLE !== 1'b1 || ADDRESS !== 32'h0000_0001) begin
            errors++; $display("FAIL triple_next_accept: enable=%b address=%h want 1 00000001", ENABLE, ADDRESS);
        end
        HANDSHAKE = 1'b1; READ = 48'h0000_0000_0055;
        tick();
        checks++; if (WB_VALID !== 1'b1 || WB_RD !== 5'd1) begin errors++; $display("FAIL triple_next_done: wb_valid=%b rd=%0d want 1 1", WB_VALID, WB_RD); end
        OP_VALID = 1'b0;
        tick();
        HANDSHAKE = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        int guard;
        OP_VALID = 1'b1; OP_CTRL = 2'b00; OP_ADDR = 32'h0000_0010; OP_RD = 5'd7;
        tick();
        acc1 = cyc;
        checks++; if (ENABLE !== 1'b1) begin errors++; $display("FAIL b2b_accept1: got %b want 1", ENABLE); end
        HANDSHAKE = 1'b1; READ = 48'h0000_0000_0A0A;
        tick();
        checks++; if (WB_VALID !== 1'b1 || WB_RD !== 5'd7 || WB_DATA !== 48'h0000_0000_0A0A || STALL !== 1'b0) begin
            errors++; $display("FAIL b2b_done1: wb_valid=%b rd=%0d data=%h stall=%b want 1 7 000000000a0a 0", WB_VALID, WB_RD, WB_DATA, STALL);
        end
        OP_RD = 5'd9; OP_ADDR = 32'h0000_0020;
        tick();
        checks++; if (STALL !== 1'b1 || ENABLE !== 1'b0 || ADDRESS !== 32'h0000_0010) begin
            errors++; $display("FAIL b2b_release: stall=%b enable=%b address=%h want 1 0 00000010", STALL, ENABLE, ADDRESS);
        end
        tick();
        checks++; if (STALL !== 1'b1 || ENABLE !== 1'b0) begin errors++; $display("FAIL b2b_release_hold: stall=%b enable=%b want 1 0", STALL, ENABLE); end
        HANDSHAKE = 1'b0;
        guard = 0;
        while (ENABLE !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        acc2 = cyc;
        checks++; if (ENABLE !== 1'b1) begin errors++; $display("FAIL b2b_accept2_timeout: enable=%b want 1", ENABLE); end
        checks++; if (acc2 - acc1 < 3) begin errors++; $display("FAIL b2b_spacing: got %0d cycles want >= 3", acc2 - acc1); end
        checks++; if (ADDRESS !== 32'h0000_0020) begin errors++; $display("FAIL b2b_address2: got %h want 00000020", ADDRESS); end
        HANDSHAKE = 1'b1; READ = 48'h0000_0000_0B0B;
        tick();
        checks++; if (WB_VALID !== 1'b1 || WB_RD !== 5'd9 || WB_DATA !== 48'h0000_0000_0B0B) begin
            errors++; $display("FAIL b2b_done2: wb_valid=%b rd=%0d data=%h want 1 9 000000000b0b", WB_VALID, WB_RD, WB_DATA);
        end
        OP_VALID = 1'b0;
        tick();
        HANDSHAKE = 1'b0;
        tick();
    endtask

`ifdef MEM_REQ_TIMEOUT_EN
    task automatic test_timeout();
        OP_VALID = 1'b1; OP_CTRL = 2'b10; OP_ADDR = 32'h0004_0004; OP_RD = 5'd3;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) begin
                checks++; if (ERROR !== 1'b0 || WB_VALID !== 1'b0 || ENABLE !== 1'b1) begin
                    errors++; $display("FAIL timeout_wait_%0d: error=%b wb_valid=%b enable=%b want 0 0 1", k, ERROR, WB_VALID, ENABLE);
                end
            end else begin
                checks++; if (ERROR !== 1'b1 || WB_VALID !== 1'b0 || STALL !== 1'b0) begin
                    errors++; $display("FAIL timeout_abort: error=%b wb_valid=%b stall=%b want 1 0 0", ERROR, WB_VALID, STALL);
                end
            end
        end
        OP_VALID = 1'b0;
        tick();
        checks++; if (ERROR !== 1'b0 || ENABLE !== 1'b0 || WB_VALID !== 1'b0 || WB_DATA !== 48'h0000_0000_0B0B) begin
            errors++; $display("FAIL timeout_release: error=%b enable=%b wb_valid=%b data=%h want 0 0 0 000000000b0b", ERROR, ENABLE, WB_VALID, WB_DATA);
        end
        tick();
        OP_VALID = 1'b1; OP_RD = 5'd5;
        tick();
        checks++; if (ENABLE !== 1'b1 || WB_RD !== 5'd5) begin errors++; $display("FAIL timeout_reaccept: enable=%b rd=%0d want 1 5", ENABLE, WB_RD); end
        HANDSHAKE = 1'b1; READ = 48'h0000_0000_0C0C;
        tick();
        checks++; if (WB_VALID !== 1'b1 || WB_DATA !== 48'h0000_0000_0C0C) begin
            errors++; $display("FAIL timeout_recover: wb_valid=%b data=%h want 1 000000000c0c", WB_VALID, WB_DATA);
        end
        OP_VALID = 1'b0;
        tick();
        HANDSHAKE = 1'b0;
        tick();
    endtask
`else
    task automatic test_no_timeout();
        OP_VALID = 1'b1; OP_CTRL = 2'b10; OP_ADDR = 32'h0004_0004; OP_RD = 5'd3;
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++; if (ERROR !== 1'b0 || ENABLE !== 1'b1 || STALL !== 1'b1) begin
                errors++; $display("FAIL no_timeout_wait_%0d: error=%b enable=%b stall=%b want 0 1 1", k, ERROR, ENABLE, STALL);
            end
        end
        HANDSHAKE = 1'b1; READ = 48'h0000_0000_0C0C;
        tick();
        checks++; if (WB_VALID !== 1'b1 || WB_DATA !== 48'h0000_0000_0C0C || WB_RD !== 5'd3) begin
            errors++; $display("FAIL no_timeout_done: wb_valid=%b data=%h rd=%0d want 1 000000000c0c 3", WB_VALID, WB_DATA, WB_RD);
        end
        OP_VALID = 1'b0;
        tick();
        HANDSHAKE = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_mid_op();
        OP_VALID = 1'b1; OP_CTRL = 2'b01; OP_ADDR = 32'h0003_0004; OP_RD = 5'd12;
        tick();
        checks++; if (ENABLE !== 1'b1) begin errors++; $display("FAIL rst_mid_accept: got %b want 1", ENABLE); end
        HANDSHAKE = 1'b1; READ = 48'h0000_0000_0D0D;
        #2 RESET = 1'b1;
        #1;
        checks++; if (ENABLE !== 1'b0 || STALL !== 1'b0 || WB_VALID !== 1'b0 || CLK_MEM !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async: enable=%b stall=%b wb_valid=%b clk_mem=%b want 0 0 0 0", ENABLE, STALL, WB_VALID, CLK_MEM);
        end
        tick();
        RESET = 1'b0;
        // HANDSHAKE is still high: stale, must not complete the op on its own
        tick();
        checks++; if (ENABLE !== 1'b1 || WB_VALID !== 1'b0) begin errors++; $display("FAIL rst_mid_reaccept: enable=%b wb_valid=%b want 1 0", ENABLE, WB_VALID); end
        HANDSHAKE = 1'b0;
        tick();
        checks++; if (ENABLE !== 1'b1 || WB_VALID !== 1'b0) begin errors++; $display("FAIL rst_mid_wait: enable=%b wb_valid=%b want 1 0", ENABLE, WB_VALID); end
        HANDSHAKE = 1'b1; READ = 48'h1234_5678_9ABC;
        tick();
        checks++; if (WB_VALID !== 1'b1 || WB_DATA !== 48'h1234_5678_9ABC || WB_RD !== 5'd12) begin
            errors++; $display("FAIL rst_mid_complete: wb_valid=%b data=%h rd=%0d want 1 123456789abc 12", WB_VALID, WB_DATA, WB_RD);
        end
        OP_VALID = 1'b0;
        tick();
        HANDSHAKE = 1'b0;
        tick();
    endtask

    task automatic test_tick_gen();
        int guard;
        guard = 0;
        while (CLK_MEM !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        checks++; if (CLK_MEM !== 1'b1) begin errors++; $display("FAIL tick_find: clk_mem=%b want 1", CLK_MEM); end
        for (int p = 0; p < 3; p++) begin
            for (int j = 1; j <= 3; j++) begin
                tick();
                checks++; if (CLK_MEM !== 1'b0) begin errors++; $display("FAIL tick_div4_low_%0d_%0d: got %b want 0", p, j, CLK_MEM); end
            end
            tick();
            checks++; if (CLK_MEM !== 1'b1) begin errors++; $display("FAIL tick_div4_high_%0d: got %b want 1", p, CLK_MEM); end
        end
        for (int j = 0; j < 8; j++) begin
            tick();
            checks++; if (u1_clk_mem !== 1'b1) begin errors++; $display("FAIL tick_div1_%0d: got %b want 1", j, u1_clk_mem); end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_horizontal_triple();
        test_back_to_back();
`ifdef MEM_REQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_op();
        test_tick_gen();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_request_sequencer.md
Name: mem_request_sequencer

Overview:
- Memory-stage sequencer of the pipelined CPU. Sits directly upstream of the matrix memory controller.
- Accepts one load op per request from the EX/MEM register and drives the controller's ENABLE/Ctrl/ADDRESS and the CLK_MEM tick.
- Stalls the pipeline until HANDSHAKE, captures the 48-bit READ result into a writeback register, then releases the controller back to its idle state.

Parameters:
- MEM_DIV, 4, CLK cycles per CLK_MEM tick (1 = tick every cycle; legal range 1..255).
- TIMEOUT_CYC, 64, max CLK cycles spent in WAIT before abort (legal range 1..65535).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- OP_VALID  in  1  load op present in EX/MEM; held until STALL is low.
- OP_CTRL  in  2  bit0 = multi-value, bit1 = vertical (controller encoding).
- OP_ADDR  in  32  {row[31:16], col[15:0]}.
- OP_RD  in  5  destination register tag.
- HANDSHAKE  in  1  controller data-ready.
- READ  in  48  controller result.
- ENABLE  out  1  controller enable.
- CTRL  out  2  registered copy of OP_CTRL.
- ADDRESS  out  32  registered copy of OP_ADDR.
- CLK_MEM  out  1  memory tick, one CLK wide.
- STALL  out  1  freeze upstream pipeline.
- WB_VALID  out  1  one-cycle result strobe.
- WB_DATA  out  48  captured READ.
- WB_RD  out  5  tag of the completed op.
- ERROR  out  1  one-cycle timeout strobe.

Behaviour:
- Reset values: all outputs 0; state IDLE; tick counter 0.
- Tick generator: free-running counter 0..MEM_DIV-1.
  - CLK_MEM = 1 when the counter is MEM_DIV-1.
  - MEM_DIV = 1 holds CLK_MEM constant 1.
  - Counter is unaffected by FSM state.
- FSM, states encoded in the shared enum:
  - IDLE: if OP_VALID, latch OP_CTRL/OP_ADDR/OP_RD into CTRL/ADDRESS/WB_RD, set ENABLE = 1 (registered), clear timeout counter, go to WAIT. Otherwise stay in IDLE.
  - WAIT: ENABLE held at 1. HANDSHAKE = 1 takes priority: latch READ into WB_DATA, go to DONE. Else, when timeout count reaches TIMEOUT_CYC-1, go to ABORT. Else increment the timeout count.
  - DONE: WB_VALID = 1 for exactly one CLK, ENABLE <= 0, go to RELEASE.
  - ABORT: ERROR = 1 for one CLK, ENABLE <= 0, WB_DATA unchanged, WB_VALID stays 0, go to RELEASE.
  - RELEASE: ENABLE = 0. Stay until HANDSHAKE = 0, then go to IDLE. This guarantees the controller passed through its idle state on a CLK_MEM tick.
- STALL: combinational, = OP_VALID && state != DONE && state != ABORT.
  - The pipeline advances exactly in the DONE/ABORT cycle.
  - A new op arriving during RELEASE stalls until it is accepted in IDLE.
- Latency: HANDSHAKE sampled high at edge N → WB_VALID high in cycle N+1. Minimum of 3 CLK from acceptance to the next acceptance.
- ADDRESS/CTRL stay stable from acceptance through RELEASE. OP_* changes while busy are ignored.
- HANDSHAKE already high in IDLE (stale): ignored. Acceptance still occurs. WAIT captures only on HANDSHAKE observed in WAIT.
- RESET mid-op: immediate return to IDLE with ENABLE = 0. The controller falls to its idle state on the next CLK. No WB_VALID is produced.
- Width rules: READ passes through unmodified; sign extension of single values is the controller's job. The timeout counter is 16 bits.

Optional Feature:
- Macro: MEM_REQ_TIMEOUT_EN.
  - Defined: timeout counter, ABORT state and ERROR are present as described.
  - Undefined: WAIT waits indefinitely for HANDSHAKE, the ABORT state is removed, ERROR is tied to 0, and TIMEOUT_CYC is unused.

Decomposition:
- Package mem_pkg:
  - state enum (IDLE, WAIT, DONE, ABORT, RELEASE).
  - Ctrl bit constants: CTRL_MULTI = bit0, CTRL_VERT = bit1.
  - Widths: ADDR_W = 32, DATA_W = 48, TAG_W = 5.
- One sub-module: mem_tick_gen (parameter MEM_DIV; ports CLK, RESET, CLK_MEM).

Test Plan:
- Single read: OP_VALID, OP_CTRL = 2'b00, OP_ADDR = 0x0002_0005, OP_RD = 7; model HANDSHAKE after 3 ticks with READ = 0xFFFF_FFFF_8001 → ADDRESS = 0x0002_0005, ENABLE = 1 until HANDSHAKE, WB_VALID pulse 1 cycle with WB_DATA = 0xFFFF_FFFF_8001 and WB_RD = 7; STALL drops in that cycle.
- Horizontal triple: OP_CTRL = 2'b01, READ = 0x0003_0002_0001 → WB_DATA = 0x0003_0002_0001; ENABLE = 0 the cycle after DONE; IDLE reached only after HANDSHAKE = 0.
- Back-to-back: a second op (OP_RD = 9) presented during RELEASE → STALL = 1 until HANDSHAKE clears; second acceptance no earlier than 3 CLK after the first; both WB_VALIDs seen in order with tags 7, 9.
- Timeout (macro defined, TIMEOUT_CYC = 8): HANDSHAKE never rises → ERROR pulse exactly 8 cycles after entering WAIT, no WB_VALID, ENABLE = 0, return to IDLE.
- Reset mid-op: assert RESET in WAIT → ENABLE, STALL, WB_VALID and CLK_MEM are 0 asynchronously; after release, a new op completes normally.
- Tick generator: MEM_DIV = 4 → CLK_MEM high on every 4th CLK; MEM_DIV = 1 → CLK_MEM constantly 1.
